// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with blink, blanking and zero suppression
// Pending/shadow double buffer: loads land in pending and become visible only at a frame boundary.
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dot,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic                  load,
  output logic                  busy,
  output logic [DIGITS-1:0]     sm_wei,
  output logic [7:0]            sm_duan,
  output logic                  frame_tick
);

  localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0]       slot_cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frame_cnt;
  logic                blink_phase;

  logic [4*DIGITS-1:0] pend_data, sh_data;
  logic [DIGITS-1:0]   pend_dot, pend_blank, pend_blink;
  logic [DIGITS-1:0]   sh_dot, sh_blank, sh_blink;
  logic                pend_lz_en, sh_lz_en;

  logic                slot_last, idx_last, frame_wrap;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          cur_nib;
  logic                cur_dot, cur_dark;
  logic [DIGITS-1:0]   wei_nxt;
  logic [7:0]          duan_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign slot_last  = (slot_cnt == SW'(CLK_DIV - 1));
  assign idx_last   = (idx == IW'(DIGITS - 1));
  assign frame_wrap = slot_last && idx_last;

  // Suppress leading blank zeros from the top digit down; digit 0 is always shown.
  always_comb begin : lz_scan
    logic lead;
    lead    = sh_lz_en;
    lz_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (sh_data[4*i +: 4] == 4'h0) && !sh_dot[i]) begin
        lz_mask[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib  = sh_data[{idx, 2'b00} +: 4];
    cur_dot  = sh_dot[idx];
    cur_dark = sh_blank[idx] | (sh_blink[idx] & blink_phase) | lz_mask[idx];
    wei_nxt  = '1;
    duan_nxt = 8'hFF;
    if ((slot_cnt >= SW'(DEAD)) && !cur_dark) begin
      wei_nxt  = ~(DIGITS'(1) << idx);
      duan_nxt = {~cur_dot, seg_decode(cur_nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_tick  <= 1'b0;
      sm_wei      <= '1;
      sm_duan     <= 8'hFF;
    end else begin
      frame_tick <= frame_wrap;
      sm_wei     <= wei_nxt;
      sm_duan    <= duan_nxt;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= idx_last ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_wrap) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // A load taken on the wrap edge sees busy=0 here, so it waits for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      pend_data  <= '0;
      pend_dot   <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      pend_lz_en <= 1'b0;
      sh_data    <= '0;
      sh_dot     <= '0;
      sh_blank   <= '1;
      sh_blink   <= '0;
      sh_lz_en   <= 1'b0;
    end else if (frame_wrap && busy) begin
      busy     <= 1'b0;
      sh_data  <= pend_data;
      sh_dot   <= pend_dot;
      sh_blank <= pend_blank;
      sh_blink <= pend_blink;
      sh_lz_en <= pend_lz_en;
    end else if (load && !busy) begin
      busy       <= 1'b1;
      pend_data  <= data;
      pend_dot   <= dot;
      pend_blank <= blank;
      pend_blink <= blink;
      pend_lz_en <= lz_en;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dot, blank, blink;
  logic        lz_en, load;
  logic        busy, frame_tick;
  logic [3:0]  sm_wei;
  logic [7:0]  sm_duan;

  int checks = 0;
  int errors = 0;
  int cyc;

  seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .DEAD(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .data(data), .dot(dot), .blank(blank), .blink(blink),
    .lz_en(lz_en), .load(load), .busy(busy), .sm_wei(sm_wei), .sm_duan(sm_duan),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; every 32 is one frame wrap.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz);
    data = d; dot = dp; blank = bl; blink = bk; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 100);
    chk({tag, "_tick"}, {31'b0, frame_tick}, 32'd1);
    chk({tag, "_align"}, cyc % 32, 32'd0);
  endtask

  // Called at a frame_tick sample; checks the next 32 samples of one frame.
  task automatic check_frame(input string tag, input logic [31:0] codes);
    logic [7:0] c, d;
    logic [3:0] w;
    int slot, dig;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      slot = k % 8;
      dig  = k / 8;
      c    = codes[8*dig +: 8];
      if (slot < 2 || c == 8'hFF) begin
        w = 4'hF; d = 8'hFF;
      end else begin
        w = ~(4'b0001 << dig); d = c;
      end
      chk($sformatf("%s_k%0d", tag, k), {19'b0, frame_tick, sm_wei, sm_duan},
          {19'b0, (k == 31), w, d});
    end
  endtask

  task automatic load_and_show(input string tag, input logic [15:0] d, input logic [3:0] dp,
                               input logic [3:0] bl, input logic lz, input logic [31:0] codes);
    do_load(d, dp, bl, 4'b0000, lz);
    chk({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    wait_tick(tag);
    chk({tag, "_busy0"}, {31'b0, busy}, 32'd0);
    check_frame(tag, codes);
  endtask

  initial begin
    int ph;
    rst = 1'b1; data = '0; dot = '0; blank = '0; blink = '0; lz_en = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wei", {28'b0, sm_wei}, 32'hF);
    chk("rst_duan", {24'b0, sm_duan}, 32'hFF);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tick", {31'b0, frame_tick}, 32'd0);

    rst = 1'b0;
    do_load(16'h1234, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    chk("first_busy", {31'b0, busy}, 32'd1);
    chk("first_dark", {20'b0, sm_wei, sm_duan}, 32'hFFF);
    wait_tick("first");
    chk("first_cyc", cyc, 32'd32);
    chk("first_busy0", {31'b0, busy}, 32'd0);
    check_frame("f1234a", 32'hF9A43099);
    check_frame("f1234b", 32'hF9A43099);

    load_and_show("lz5",    16'h0005, 4'b0000, 4'b0000, 1'b1, 32'hFFFFFF92);
    load_and_show("lz0",    16'h0000, 4'b0000, 4'b0000, 1'b1, 32'hFFFFFFC0);
    load_and_show("lzdot",  16'h0005, 4'b0100, 4'b0000, 1'b1, 32'hFF40C092);
    load_and_show("nolz",   16'h0005, 4'b0000, 4'b0000, 1'b0, 32'hC0C0C092);
    load_and_show("blank3", 16'h1234, 4'b0000, 4'b1000, 1'b0, 32'hFFA4B099);

    do_load(16'hABCD, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_tick("blk");
    for (int f = 0; f < 4; f++) begin
      ph = (cyc / 32 / 2) % 2;
      check_frame($sformatf("blk%0d", f), ph ? 32'h8883C6FF : 32'h8883C6A1);
    end

    do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("dbl_busy", {31'b0, busy}, 32'd1);
    wait_tick("dbl");
    check_frame("dbl", 32'hF9F9F9F9);
    repeat (31) @(negedge clk);
    do_load(16'h3333, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("wedge_tick", {31'b0, frame_tick}, 32'd1);
    chk("wedge_busy", {31'b0, busy}, 32'd1);
    check_frame("wedge_old", 32'hF9F9F9F9);
    chk("wedge_busy0", {31'b0, busy}, 32'd0);
    check_frame("wedge_new", 32'hB0B0B0B0);

    do_load(16'h5555, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    repeat (4) @(negedge clk);
    chk("prerst_busy", {31'b0, busy}, 32'd1);
    chk("prerst_lit", {20'b0, sm_wei, sm_duan}, 32'hEB0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {18'b0, frame_tick, busy, sm_wei, sm_duan}, 32'hFFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_busy", {31'b0, busy}, 32'd0);
    wait_tick("post");
    chk("post_cyc", cyc, 32'd32);
    chk("post_busy0", {31'b0, busy}, 32'd0);
    check_frame("post_dark", 32'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Parameters
REQ-001 DIGITS, 4, number of multiplexed digits, legal range 2..8.
REQ-002 CLK_DIV, 50000, clk cycles per digit slot, minimum 4.
REQ-003 DEAD, 2, leading cycles of each slot with all digits off (anti-ghosting), legal range 1..CLK_DIV-2.
REQ-004 BLINK_FRAMES, 125, complete frames per blink half-period, minimum 1.

Interface
REQ-005 clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 data  in  4*DIGITS  hex nibble per digit; nibble i drives digit i; digit 0 is rightmost.
REQ-008 dot  in  DIGITS  1 = decimal point of digit i lit.
REQ-009 blank  in  DIGITS  1 = digit i forced dark.
REQ-010 blink  in  DIGITS  1 = digit i dark during the blink-off phase.
REQ-011 lz_en  in  1  1 = leading-zero suppression enabled.
REQ-012 load  in  1  request to capture data, dot, blank, blink and lz_en.
REQ-013 busy  out  1  1 = a captured set is waiting to be applied.
REQ-014 sm_wei  out  DIGITS  digit enables, active-low, at most one bit low.
REQ-015 sm_duan  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-016 frame_tick  out  1  one-cycle pulse at every frame wrap.

Function
REQ-017 A slot counter SHALL count cycles 0..CLK_DIV-1; at CLK_DIV-1 it SHALL return to 0 and the digit index SHALL advance, with DIGITS-1 wrapping to 0.
REQ-018 Frame wrap SHALL be the edge at which the slot counter is at CLK_DIV-1 and the digit index is at DIGITS-1; frame_tick SHALL be 1 for the cycle after that edge.
REQ-019 sm_wei and sm_duan SHALL be registered, and SHALL reflect the slot counter and digit index of the previous cycle (one-cycle latency).
REQ-020 While the slot counter is below DEAD, sm_wei SHALL be all ones and sm_duan SHALL be 0xFF.
REQ-021 Otherwise, sm_wei SHALL be all ones except bit idx = 0, and sm_duan[6:0] SHALL decode the shadow nibble as follows: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E (hex codes, bit7 excluded); sm_duan[7] SHALL be the inverse of the shadow dot.
REQ-022 A digit is dark when any of the following holds: its shadow blank bit is 1; or its shadow blink bit is 1 and the blink phase is 1; or it is zero-suppressed.
REQ-023 A dark digit SHALL drive sm_wei all ones and sm_duan 0xFF for the whole slot; scan timing SHALL be unchanged.
REQ-024 Zero suppression (shadow lz_en=1): starting from digit DIGITS-1 and moving down, each digit whose nibble is 0 and whose dot is 0 SHALL be suppressed until the first digit that fails that test.
REQ-025 Digit 0 SHALL never be zero-suppressed.
REQ-026 A frame counter SHALL count 0..BLINK_FRAMES-1 at frame wraps; on its wrap the blink phase SHALL toggle.
REQ-027 Load handshake: if load=1 and busy=0 at an edge, all inputs of REQ-007..REQ-011 SHALL be captured into a pending register, and busy SHALL become 1.
REQ-028 A load while busy=1 SHALL be ignored.
REQ-029 At a frame wrap with busy=1, pending SHALL be copied to shadow and busy SHALL clear; the new content is first visible in digit 0 of the next frame.
REQ-030 A load accepted on the same edge as a frame wrap SHALL NOT bypass the pending register; it SHALL be applied at the following wrap.

Reset
REQ-031 While rst=1, outputs SHALL be: sm_wei all ones, sm_duan 0xFF, busy 0, frame_tick 0.
REQ-032 Reset SHALL clear the slot counter, digit index, frame counter and blink phase to 0, and pending/shadow data, dot, blink and lz_en to 0.
REQ-033 Reset SHALL set shadow blank to all ones, so the display stays dark until the first applied load.
REQ-034 Reset asserted mid-frame SHALL abort the scan immediately and discard any pending load.

Verification (DIGITS=4, CLK_DIV=8, DEAD=2, BLINK_FRAMES=2)
REQ-035 Release reset, load data=0x1234, dot=0010b, blank=0, blink=0 -> busy=1 until the first wrap; the following frame shows sm_wei=1110/duan=0x99, 1101/0x30, 1011/0xA4, 0111/0xF9, each for 6 cycles after 2 dark cycles.
REQ-036 Free-running scan -> frame_tick pulses exactly every 32 cycles; sm_wei is never low in more than one bit.
REQ-037 Load 0x0005 with lz_en=1 -> digits 3..1 dark, digit 0 shows 0x92; load 0x0000 with lz_en=1 -> digit 0 shows 0xC0.
REQ-038 blink=0001b -> digit 0 is lit for 2 frames, then dark for 2 frames, repeating; other digits are unaffected.
REQ-039 Second load while busy=1, and a load on the wrap edge -> the second load has no effect; the wrap-edge load appears one frame later.
REQ-040 Assert rst mid-slot with a load pending -> outputs go to reset values asynchronously; after release the display stays dark and busy=0.
